// File: rtl/fre_bcd.sv
// Converts a 20-bit binary frequency reading into seven packed BCD digits.
// Uses one double-dabble step per cycle and adds a leading-zero blanking mask.
module fre_bcd (
    input  logic        clk_i,
    input  logic        rst,
    input  logic [19:0] prob_khz_i,
    input  logic        low_fre_sign_i,
    input  logic        refresh_i,
    output logic [27:0] bcd_o,
    output logic        unit_hz_o,
    output logic [6:0]  blank_o,
    output logic        valid_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [19:0] bin_q, bin_d;
    logic [19:0] last_q, last_d;
    logic        flag_q, flag_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [27:0] scratch_q, scratch_d;
    logic [27:0] bcd_q, bcd_d;
    logic        unit_q, unit_d;
    logic [6:0]  blank_q, blank_d;
    logic        valid_q, valid_d;

    logic [27:0] adjusted;
    logic [6:0]  blank_scan;

    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < 7; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // blank_scan[i] is set when every digit from the top down to i is zero.
    always_comb begin
        blank_scan    = 7'b0;
        blank_scan[6] = (scratch_q[27:24] == 4'd0);
        for (int i = 5; i >= 1; i--) begin
            blank_scan[i] = blank_scan[i+1] && (scratch_q[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        last_d    = last_q;
        flag_d    = flag_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        unit_d    = unit_q;
        blank_d   = blank_q;
        valid_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (refresh_i || ({low_fre_sign_i, prob_khz_i} != {flag_q, last_q})) begin
                    bin_d     = prob_khz_i;
                    last_d    = prob_khz_i;
                    flag_d    = low_fre_sign_i;
                    scratch_d = 28'd0;
                    cnt_d     = 5'd0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                scratch_d = {adjusted[26:0], bin_q[19]};
                bin_d     = {bin_q[18:0], 1'b0};
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == 5'd19) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_d   = scratch_q;
                unit_d  = flag_q;
                blank_d = blank_scan;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q   <= StIdle;
            bin_q     <= 20'd0;
            last_q    <= 20'd0;
            flag_q    <= 1'b0;
            cnt_q     <= 5'd0;
            scratch_q <= 28'd0;
            bcd_q     <= 28'd0;
            unit_q    <= 1'b0;
            blank_q   <= 7'b1111110;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            last_q    <= last_d;
            flag_q    <= flag_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            unit_q    <= unit_d;
            blank_q   <= blank_d;
            valid_q   <= valid_d;
        end
    end

    assign bcd_o     = bcd_q;
    assign unit_hz_o = unit_q;
    assign blank_o   = blank_q;
    assign valid_o   = valid_q;
    assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_fre_bcd.sv
// Directed and random checks of fre_bcd against a decimal-arithmetic reference.
module tb_fre_bcd;

    logic        clk_i = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] prob_khz_i = 20'd0;
    logic        low_fre_sign_i = 1'b0;
    logic        refresh_i = 1'b0;
    logic [27:0] bcd_o;
    logic        unit_hz_o;
    logic [6:0]  blank_o;
    logic        valid_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    fre_bcd dut (
        .clk_i          (clk_i),
        .rst            (rst),
        .prob_khz_i     (prob_khz_i),
        .low_fre_sign_i (low_fre_sign_i),
        .refresh_i      (refresh_i),
        .bcd_o          (bcd_o),
        .unit_hz_o      (unit_hz_o),
        .blank_o        (blank_o),
        .valid_o        (valid_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [27:0] bcd_of(input int v);
        logic [27:0] r;
        int p;
        r = 28'd0;
        p = 1;
        for (int i = 0; i < 7; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Digits 6..i are all zero exactly when the value is below 10**i.
    function automatic logic [6:0] blank_of(input int v);
        logic [6:0] b;
        int p;
        b = 7'd0;
        p = 10;
        for (int i = 1; i < 7; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Advance until valid_o is seen; n counts edges since the start edge.
    task automatic wait_valid(input int n0, output int n);
        n = n0;
        while (!valid_o && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int v, input logic f, input int n);
        check({tag, "_latency"}, 64'(n), 64'd21);
        check({tag, "_bcd"}, 64'(bcd_o), 64'(bcd_of(v)));
        check({tag, "_unit"}, 64'(unit_hz_o), 64'(f));
        check({tag, "_blank"}, 64'(blank_o), 64'(blank_of(v)));
    endtask

    // Present a value before edge k, then follow the conversion through.
    task automatic convert(input string tag, input int v, input logic f, input logic refresh);
        int n;
        prob_khz_i     = 20'(v);
        low_fre_sign_i = f;
        refresh_i      = refresh;
        step();
        refresh_i = 1'b0;
        check({tag, "_busy"}, 64'(busy_o), 64'd1);
        wait_valid(0, n);
        check_result(tag, v, f, n);
        step();
        check({tag, "_pulse"}, 64'(valid_o), 64'd0);
        check({tag, "_idle"}, 64'(busy_o), 64'd0);
        check({tag, "_hold"}, 64'(bcd_o), 64'(bcd_of(v)));
    endtask

    initial begin
        int n;
        int bad_valid;
        int bad_busy;
        int v;
        logic f;

        step();
        step();
        check("reset_bcd", 64'(bcd_o), 64'd0);
        check("reset_blank", 64'(blank_o), 64'(7'b1111110));
        check("reset_valid", 64'(valid_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        rst = 1'b0;

        // Inputs matching the reset capture must never start a conversion.
        bad_valid = 0;
        bad_busy  = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (valid_o) bad_valid++;
            if (busy_o) bad_busy++;
        end
        check("idle_valid", 64'(bad_valid), 64'd0);
        check("idle_busy", 64'(bad_busy), 64'd0);
        check("idle_bcd", 64'(bcd_o), 64'd0);
        check("idle_blank", 64'(blank_o), 64'(7'b1111110));

        convert("k50000", 50000, 1'b0, 1'b0);
        check("k50000_blank_lit", 64'(blank_o), 64'(7'b1100000));
        convert("max", 1048575, 1'b0, 1'b0);
        check("max_bcd_lit", 64'(bcd_o), 64'h1048575);
        convert("hz7", 7, 1'b1, 1'b0);

        // Input change mid-conversion is ignored, then picked up in idle.
        prob_khz_i     = 20'd123;
        low_fre_sign_i = 1'b0;
        step();
        repeat (4) step();
        prob_khz_i = 20'd456;
        wait_valid(4, n);
        check_result("chg123", 123, 1'b0, n);
        step();
        check("chg_restart_busy", 64'(busy_o), 64'd1);
        check("chg_restart_valid", 64'(valid_o), 64'd0);
        wait_valid(0, n);
        check_result("chg456", 456, 1'b0, n);

        convert("v999", 999, 1'b0, 1'b0);
        repeat (3) step();
        check("no_restart_busy", 64'(busy_o), 64'd0);
        convert("refresh999", 999, 1'b0, 1'b1);

        // Reset in the middle of converting 777 must abort without a pulse.
        prob_khz_i = 20'd777;
        step();
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valid", 64'(valid_o), 64'd0);
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_bcd", 64'(bcd_o), 64'd0);
        check("abort_blank", 64'(blank_o), 64'(7'b1111110));
        check("abort_unit", 64'(unit_hz_o), 64'd0);
        step();
        check("post_rst_busy", 64'(busy_o), 64'd1);
        wait_valid(0, n);
        check_result("post_rst777", 777, 1'b0, n);

        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 1048575));
            f = 1'($urandom_range(0, 1));
            convert("rand", v, f, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
